// File: rtl/sprite_motion_fsm.sv
// sprite_motion_fsm: per-frame fixed-point player motion engine.
// Integrates X/Y positions once per frame from keys, collision flags and
// external drift, with an explicit GROUNDED/CLIMBING/JUMPING/FALLING machine.
// Optional build macro DOUBLE_JUMP_EN enables a single mid-air jump.
module sprite_motion_fsm #(
    parameter int unsigned POS_W       = 11,
    parameter int unsigned SPEED_W     = 16,
    parameter int unsigned FRAC_BITS   = 6,
    parameter int          INITIAL_X   = 280,
    parameter int          INITIAL_Y   = 185,
    parameter int          X_MIN       = -9,
    parameter int          X_MAX       = 570,
    parameter int          Y_MIN       = 0,
    parameter int          Y_MAX       = 415,
    parameter int          WALK_SPEED  = 200,
    parameter int          CLIMB_SPEED = 100,
    parameter int          JUMP_SPEED  = 300,
    parameter int          GRAVITY     = 10,
    parameter int          MAX_Y_SPEED = 230
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic                     leftPressed,
    input  logic                     rightPressed,
    input  logic                     upPressed,
    input  logic                     downPressed,
    input  logic                     onRope,
    input  logic                     onBlock,
    input  logic [3:0]               HitEdgeCode,
    input  logic signed [SPEED_W-1:0] addedSpeed,
    output logic signed [POS_W-1:0]  topLeftX,
    output logic signed [POS_W-1:0]  topLeftY,
    output logic [1:0]               motionState
);

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        CLIMBING = 2'd1,
        JUMPING  = 2'd2,
        FALLING  = 2'd3
    } motionT;

    localparam int SCALE = 1 << FRAC_BITS;
    localparam int X_LO  = X_MIN * SCALE;
    localparam int X_HI  = X_MAX * SCALE;
    localparam int Y_LO  = Y_MIN * SCALE;
    localparam int Y_HI  = Y_MAX * SCALE;

    motionT             state;
    motionT             stateNext;
    logic signed [31:0] xFix;
    logic signed [31:0] yFix;
    logic signed [31:0] ySpeed;
    logic               jumpReq;
    logic               upPressedD;

    logic               floorHit;
    logic               ceilHit;
    logic               upRise;
    logic               jumpNow;
    logic signed [31:0] xSpeed;
    logic signed [31:0] xSum;
    logic signed [31:0] xFixNext;
    logic signed [31:0] yGrav;
    logic signed [31:0] ySpeedSel;
    logic signed [31:0] ySpeedNext;
    logic signed [31:0] ySum;
    logic signed [31:0] yFixNext;
    logic               unusedEdgeBits;

`ifdef DOUBLE_JUMP_EN
    logic               airJumpUsed;
    logic               airJumpNext;
`endif

    assign floorHit       = onBlock & HitEdgeCode[0];
    assign ceilHit        = onBlock & HitEdgeCode[2];
    assign upRise         = upPressed & ~upPressedD;
    // A rising edge in the same cycle as startOfFrame counts for that frame
    assign jumpNow        = jumpReq | upRise;
    assign yGrav          = ySpeed + GRAVITY;
    assign unusedEdgeBits = HitEdgeCode[1] ^ HitEdgeCode[3];

    // Jump request capture: latch up-key rising edges, drop at every frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jumpReq    <= 1'b0;
            upPressedD <= 1'b0;
        end else begin
            upPressedD <= upPressed;
            if (startOfFrame) begin
                jumpReq <= 1'b0;
            end else if (upRise) begin
                jumpReq <= 1'b1;
            end
        end
    end

    // State register: motion state and fixed-point kinematics update per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FALLING;
            xFix   <= INITIAL_X * SCALE;
            yFix   <= INITIAL_Y * SCALE;
            ySpeed <= '0;
`ifdef DOUBLE_JUMP_EN
            airJumpUsed <= 1'b0;
`endif
        end else if (startOfFrame) begin
            state  <= stateNext;
            xFix   <= xFixNext;
            yFix   <= yFixNext;
            ySpeed <= ySpeedNext;
`ifdef DOUBLE_JUMP_EN
            airJumpUsed <= airJumpNext;
`endif
        end
    end

    // Horizontal speed selection and clamped X integration
    always_comb begin
        xSpeed = 32'(addedSpeed);
        if (rightPressed && !leftPressed) begin
            xSpeed = WALK_SPEED;
        end else if (leftPressed && !rightPressed) begin
            xSpeed = -WALK_SPEED;
        end
        xSum     = xFix + xSpeed;
        xFixNext = xSum;
        if (xSum > X_HI) begin
            xFixNext = X_HI;
        end else if (xSum < X_LO) begin
            xFixNext = X_LO;
        end
    end

    // Next-state logic: transition priority, vertical speed and Y bounds
    always_comb begin
        stateNext = state;
        ySpeedSel = ySpeed;
`ifdef DOUBLE_JUMP_EN
        airJumpNext = airJumpUsed;
`endif
        unique case (state)
            GROUNDED: begin
                if (jumpNow) begin
                    stateNext = JUMPING;
                    ySpeedSel = -JUMP_SPEED;
                end else if (onRope && (upPressed || downPressed)) begin
                    stateNext = CLIMBING;
                end else if (!floorHit && !onRope) begin
                    stateNext = FALLING;
                end else begin
                    ySpeedSel = '0;
                end
            end
            CLIMBING: begin
                if (!onRope) begin
                    stateNext = FALLING;
                    ySpeedSel = '0;
                end else if (jumpNow && (leftPressed || rightPressed)) begin
                    stateNext = JUMPING;
                    ySpeedSel = -JUMP_SPEED;
                end else if (upPressed && !downPressed) begin
                    ySpeedSel = -CLIMB_SPEED;
                end else if (downPressed && !upPressed) begin
                    ySpeedSel = CLIMB_SPEED;
                end else begin
                    ySpeedSel = '0;
                end
            end
            JUMPING: begin
                if (ceilHit) begin
                    stateNext = FALLING;
                    ySpeedSel = '0;
`ifdef DOUBLE_JUMP_EN
                end else if (jumpNow && !airJumpUsed) begin
                    stateNext   = JUMPING;
                    ySpeedSel   = -JUMP_SPEED;
                    airJumpNext = 1'b1;
`endif
                end else if (yGrav >= 0) begin
                    stateNext = FALLING;
                    ySpeedSel = yGrav;
                end else begin
                    ySpeedSel = yGrav;
                end
            end
            FALLING: begin
                if (floorHit) begin
                    stateNext = GROUNDED;
                    ySpeedSel = '0;
                end else if (onRope) begin
                    stateNext = CLIMBING;
                    ySpeedSel = '0;
`ifdef DOUBLE_JUMP_EN
                end else if (jumpNow && !airJumpUsed) begin
                    stateNext   = JUMPING;
                    ySpeedSel   = -JUMP_SPEED;
                    airJumpNext = 1'b1;
`endif
                end else if (yGrav > MAX_Y_SPEED) begin
                    ySpeedSel = MAX_Y_SPEED;
                end else begin
                    ySpeedSel = yGrav;
                end
            end
            default: begin
                stateNext = FALLING;
            end
        endcase

        // Screen edges land a falling sprite and stop a rising one
        ySum       = yFix + ySpeedSel;
        yFixNext   = ySum;
        ySpeedNext = ySpeedSel;
        if (ySum >= Y_HI) begin
            yFixNext = Y_HI;
            if (stateNext == FALLING) begin
                stateNext  = GROUNDED;
                ySpeedNext = '0;
            end
        end else if (ySum <= Y_LO) begin
            yFixNext = Y_LO;
            if (stateNext == JUMPING) begin
                stateNext  = FALLING;
                ySpeedNext = '0;
            end
        end
`ifdef DOUBLE_JUMP_EN
        if (stateNext == GROUNDED || stateNext == CLIMBING) begin
            airJumpNext = 1'b0;
        end
`endif
    end

    // Outputs: integer pixel positions (floor) and current state
    always_comb begin
        topLeftX    = POS_W'(xFix >>> FRAC_BITS);
        topLeftY    = POS_W'(yFix >>> FRAC_BITS);
        motionState = state;
    end

endmodule

// File: tb/tb_sprite_motion_fsm.sv
// Directed bench for sprite_motion_fsm: free fall to the floor, jump/ceiling,
// jump request handling, X clamping/drift, rope climbing and air jumps.
module tb_sprite_motion_fsm;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               leftPressed = 1'b0;
    logic               rightPressed = 1'b0;
    logic               upPressed = 1'b0;
    logic               downPressed = 1'b0;
    logic               onRope = 1'b0;
    logic               onBlock = 1'b0;
    logic [3:0]         HitEdgeCode = 4'b0000;
    logic signed [15:0] addedSpeed = 16'sd0;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic [1:0]         motionState;

    int checks = 0;
    int failures = 0;

    sprite_motion_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .leftPressed  (leftPressed),
        .rightPressed (rightPressed),
        .upPressed    (upPressed),
        .downPressed  (downPressed),
        .onRope       (onRope),
        .onBlock      (onBlock),
        .HitEdgeCode  (HitEdgeCode),
        .addedSpeed   (addedSpeed),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .motionState  (motionState)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int expX, input int expYfix,
                            input int expState);
        check({tag, ":x"}, topLeftX, expX);
        check({tag, ":yfix"}, dut.yFix, expYfix);
        check({tag, ":y"}, topLeftY, expYfix >>> 6);
        check({tag, ":state"}, motionState, expState);
    endtask

    task automatic frame();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic pulseUp();
        @(negedge clk);
        upPressed = 1'b1;
        @(negedge clk);
        upPressed = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset        = 1'b1;
        startOfFrame = 1'b0;
        leftPressed  = 1'b0;
        rightPressed = 1'b0;
        upPressed    = 1'b0;
        downPressed  = 1'b0;
        onRope       = 1'b0;
        onBlock      = 1'b0;
        HitEdgeCode  = 4'b0000;
        addedSpeed   = 16'sd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkAll("reset", 280, 11840, 3);
    endtask

    initial begin
        int y;
        int spd;
        int st;

        // Free fall from reset until the bottom edge lands the sprite
        doReset();
        frame(); checkAll("fall1", 280, 11850, 3);
        frame(); checkAll("fall2", 280, 11870, 3);
        frame(); checkAll("fall3", 280, 11900, 3);
        y = 11900; spd = 30; st = 3;
        for (int k = 4; k <= 75; k++) begin
            frame();
            spd = (spd + 10 > 230) ? 230 : spd + 10;
            y = y + spd;
            if (y >= 26560) begin
                y = 26560; st = 0; spd = 0;
            end
            checkAll("freefall", 280, y, st);
        end
        checkAll("landYmax", 280, 26560, 0);

        // Jump from the ground, ceiling bounce, held key, dropped request
        doReset();
        onBlock = 1'b1; HitEdgeCode = 4'b0001;
        frame(); checkAll("land", 280, 11840, 0);
        pulseUp();
        frame(); checkAll("jump", 280, 11540, 2);
        upPressed = 1'b1; HitEdgeCode = 4'b0100;
        frame(); checkAll("ceiling", 280, 11540, 3);
        HitEdgeCode = 4'b0001;
        frame(); checkAll("reland", 280, 11540, 0);
        frame(); checkAll("heldUp", 280, 11540, 0);
        upPressed = 1'b0; onBlock = 1'b0;
        frame(); checkAll("walkOff", 280, 11540, 3);
        onBlock = 1'b1; HitEdgeCode = 4'b0001;
        pulseUp();
        frame(); checkAll("landReq", 280, 11540, 0);
        frame(); checkAll("noQueue", 280, 11540, 0);
        @(negedge clk);
        upPressed = 1'b1; startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        checkAll("sameCycleJump", 280, 11240, 2);
        upPressed = 1'b0; onBlock = 1'b0; HitEdgeCode = 4'b0000;
        frame(); checkAll("rise", 280, 10950, 2);

        // Horizontal drift, walking and clamping at both edges
        addedSpeed = 16'sd18496;
        frame(); check("xDrift", topLeftX, 569);
        addedSpeed = 16'sd0; rightPressed = 1'b1;
        frame(); check("xClampHi1", topLeftX, 570);
        frame(); check("xClampHi2", topLeftX, 570);
        rightPressed = 1'b0; leftPressed = 1'b1;
        frame(); check("xWalkLeft", topLeftX, 566);
        rightPressed = 1'b1; addedSpeed = 16'sd64;
        frame(); check("xBoth1", topLeftX, 567);
        frame(); check("xBoth2", topLeftX, 568);
        leftPressed = 1'b0; rightPressed = 1'b0; addedSpeed = 16'sh8000;
        frame(); check("xDriftLeft", topLeftX, 56);
        frame(); check("xClampLo1", topLeftX, -9);
        leftPressed = 1'b1;
        frame(); check("xClampLo2", topLeftX, -9);
        leftPressed = 1'b0; addedSpeed = 16'sd0;

        // Rope: catch, climb down/up, let go, regrab, jump off sideways
        doReset();
        onRope = 1'b1; downPressed = 1'b1;
        frame(); checkAll("grab", 280, 11840, 1);
        frame(); checkAll("climbDn1", 280, 11940, 1);
        frame(); checkAll("climbDn2", 280, 12040, 1);
        upPressed = 1'b1;
        frame(); checkAll("climbBoth", 280, 12040, 1);
        downPressed = 1'b0;
        frame(); checkAll("climbUp", 280, 11940, 1);
        onRope = 1'b0;
        frame(); checkAll("ropeDrop", 280, 11940, 3);
        onRope = 1'b1;
        frame(); checkAll("regrab", 280, 11940, 1);
        @(negedge clk);
        upPressed = 1'b0;
        @(negedge clk);
        upPressed = 1'b1; rightPressed = 1'b1; startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        checkAll("ropeJump", 283, 11640, 2);

        // Airborne jump requests
        onRope = 1'b0; rightPressed = 1'b0; upPressed = 1'b0;
        pulseUp();
        frame();
`ifdef DOUBLE_JUMP_EN
        checkAll("airJump1", 283, 11340, 2);
`else
        checkAll("airJump1", 283, 11350, 2);
`endif
        pulseUp();
        frame();
`ifdef DOUBLE_JUMP_EN
        checkAll("airJump2", 283, 11050, 2);
`else
        checkAll("airJump2", 283, 11070, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
